// File: rtl/mp_add_pkg.sv
// rtl/mp_add_pkg.sv - shared types and sizing helpers for the multi-precision add sequencer
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mp_state_t;

  localparam int LIMB_W = 64;

  // A single-limb build would give $clog2 of 0; keep the index at least one bit wide.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/CSA_64bit.sv
// rtl/CSA_64bit.sv - 64-bit carry-select adder shared by the limb sequencer
module CSA_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic [63:0] sum,
  output logic        c_out
);

  localparam int BLK = 16;
  localparam int NB  = 64 / BLK;

  logic [NB:0] carry;

  assign carry[0] = c_in;

  // Each block precomputes both carry-in outcomes; the incoming carry only drives the select.
  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [BLK:0] r0;
    logic [BLK:0] r1;

    assign r0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
    assign r1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + (BLK+1)'(1);

    assign sum[g*BLK +: BLK] = carry[g] ? r1[BLK-1:0] : r0[BLK-1:0];
    assign carry[g+1]        = carry[g] ? r1[BLK]     : r0[BLK];
  end

  assign c_out = carry[NB];

endmodule

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - WORDS x 64-bit add/subtract, one limb per cycle through one shared adder
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LIMB_W*WORDS-1:0] a,
  input  logic [LIMB_W*WORDS-1:0] b,
  input  logic                    c_in,
  input  logic                    op_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LIMB_W*WORDS-1:0] sum,
  output logic                    c_out
);

  localparam int N     = LIMB_W * WORDS;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  mp_state_t          state_q;
  mp_state_t          state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [N-1:0]       a_r;
  logic [N-1:0]       b_r;
  logic               op_sub_r;
  logic [N-1:0]       sum_q;
  logic               c_out_q;
  logic               accept;
  logic               last_limb;

  logic [LIMB_W-1:0]  add_a;
  logic [LIMB_W-1:0]  add_b;
  logic [LIMB_W-1:0]  add_sum;
  logic               add_cout;

  assign last_limb = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_limb) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1 across the whole width, so b is inverted limb by limb.
  assign add_a = a_r[idx_q*LIMB_W +: LIMB_W];
  assign add_b = b_r[idx_q*LIMB_W +: LIMB_W] ^ {LIMB_W{op_sub_r}};

  CSA_64bit u_csa (
    .a     (add_a),
    .b     (add_b),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      op_sub_r <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
    end else if (accept) begin
      a_r      <= a;
      b_r      <= b;
      op_sub_r <= op_sub;
      idx_q    <= '0;
      carry_q  <= c_in ^ op_sub;
    end else if (state_q == RUN) begin
      sum_q[idx_q*LIMB_W +: LIMB_W] <= add_sum;
      carry_q <= add_cout;
      if (last_limb) begin
        idx_q   <= '0;
        c_out_q <= add_cout;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add/subtract sequencer that time-shares one 64-bit carry-select adder (`CSA_64bit`) to compute WORDS×64-bit results, one 64-bit limb per cycle, with the carry chained through a register. It sits between a requester and the shared adder. It owns operand capture, limb selection, carry sequencing and a valid/ready handshake on both sides.

## Interface
Parameters:
- `WORDS`, 4: number of 64-bit limbs. Must be 2 or more. Total operand width is N = 64·WORDS.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: request present.
- `in_ready`, output, 1: block can accept a request.
- `a`, input, N: operand A.
- `b`, input, N: operand B.
- `c_in`, input, 1: carry-in for add, borrow-in for subtract.
- `op_sub`, input, 1: 0 computes a+b+c_in; 1 computes a−b−c_in.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer accepts the result.
- `sum`, output, N: result.
- `c_out`, output, 1: final carry. For subtract, 1 means no borrow.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `a`, `b`, `op_sub` into registers; set limb index `idx`=0; go to RUN.
  - Initial carry register = `c_in` for add, or ~`c_in` for subtract.
- **RUN**
  - The adder sees `a_r[idx]` and `b_r[idx]` (b is limb-inverted when `op_sub`=1), with carry register as its `c_in`.
  - Each edge: write adder sum into `sum[idx]`, load adder `c_out` into the carry register, increment `idx`.
  - On the edge where `idx`=WORDS−1: go to DONE. `c_out` takes the final carry.
- **DONE**
  - `out_valid`=1.
  - `sum` and `c_out` are held stable until `out_valid`&&`out_ready`, then go to IDLE.
- Input changes outside the accepting edge have no effect, because operands are registered.
- `in_ready`=0 in RUN and DONE. `in_valid` is ignored there, with no queueing.
- Arithmetic is modulo 2^N. `sum` limb k is bits [64k+63:64k]. No overflow flag.
- Sum limbs not yet written during RUN keep their previous values. Consumers sample only when `out_valid`=1.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - state IDLE, `idx`=0, carry register 0;
  - `sum`=0, `c_out`=0, `out_valid`=0;
  - `in_ready`=1 (decoded from IDLE).
- Reset takes effect immediately in any state, including mid-RUN. The partial result is discarded. The first edge after `rst_n` rises may accept a new request.
- Latency: accept on edge T means the last limb is written at edge T+WORDS, and `out_valid` is high from T+WORDS. For WORDS=4, that is 4 cycles.
- Throughput: one request per WORDS+2 cycles at best: accept, WORDS RUN edges, one DONE cycle with `out_ready`=1, and a return to IDLE. Back-to-back accept in the DONE cycle is not supported.
- `out_ready` held low stalls DONE indefinitely with outputs constant.
- `out_valid` and `in_ready` are never high together.
- The adder path is combinational within one cycle. Its only registered boundary is the carry and sum registers.

## Structure
- Package `mp_add_pkg`:
  - state typedef `mp_state_t` {IDLE, RUN, DONE};
  - localparam `LIMB_W`=64;
  - function for index width = $clog2(WORDS).
- One sub-module: a single `CSA_64bit` instance as the shared adder.
- The FSM, operand registers, limb mux/demux and carry register are local to `mp_add_seq`.
- Bench: compare against a behavioural N-bit `+`/`−` reference model with `error_flag` reporting, in the existing adder-test style.

## Test plan
- **Carry across all limbs:** `a`=all-ones (256-bit), `b`=all-ones, `c_in`=1, add → `sum`=all-ones, `c_out`=1; `out_valid` exactly 4 cycles after accept.
- **Inter-limb carry:** `a`=64'hFFFFFFFFFFFFFFFF (limb 0 only), `b`=1, `c_in`=0 → `sum` limb1=1, limb0=0, others 0, `c_out`=0.
- **Subtract with borrow:** `a`=0, `b`=1, `c_in`=0, `op_sub`=1 → `sum`=all-ones, `c_out`=0. Then `a`=5, `b`=3 → `sum`=2, `c_out`=1.
- **Backpressure:** `out_ready`=0 for 3 cycles in DONE → `sum`/`c_out`/`out_valid` stable, `in_ready`=0, a new `in_valid` is ignored. On `out_ready`=1 → IDLE next cycle.
- **Reset mid-RUN:** drop `rst_n` at `idx`=2 → immediately `out_valid`=0, `sum`=0, `c_out`=0, `in_ready`=1. The next request (`a`=64'hA180C9BFC723279F, `b`=64'hA282AC73ED441906 in limb 0) gives the correct result.
- **Operand isolation:** change `a`/`b` every cycle during RUN → result matches the operands captured at accept.
